// File: rtl/mem_responder_multicycle_pkg.sv
// Shared types and default widths for the multicycle memory responder.
// Holds the FSM state encoding and the request legality rule.
package mem_responder_multicycle_pkg;

    localparam int MRM_DATA_W = 16;
    localparam int MRM_ADDR_W = 8;
    localparam int MRM_CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        WAIT    = 2'b01,
        RESPOND = 2'b10
    } state_t;

    // Exactly one of load/mem_write, and an address inside the array.
    function automatic logic is_legal(input logic load, input logic write, input logic in_range);
        return (load ^ write) & in_range;
    endfunction

endpackage

// File: rtl/mem_responder_multicycle_array.sv
// Single-port DEPTH x DATA_W storage: synchronous write, combinational read.
// Contents are intentionally never reset.
module mem_array #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [IDX_W-1:0]  idx;
    logic              unused_addr_hi;

    // Callers only access legal addresses, so dropping upper bits is safe.
    assign idx            = addr[IDX_W-1:0];
    assign unused_addr_hi = ^addr;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/mem_responder_multicycle.sv
// Fixed-latency memory responder: accepts a request in IDLE, waits
// WAIT_CYCLES cycles, then completes with a one-cycle mem_ready strobe.
module mem_responder_multicycle
    import mem_responder_multicycle_pkg::*;
#(
    parameter int DATA_W      = MRM_DATA_W,
    parameter int ADDR_W      = MRM_ADDR_W,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_enable,
    input  logic              load,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_ready,
    output logic              mem_busy,
    output logic              mem_error
);

    localparam logic [ADDR_W:0]    DEPTH_L  = (ADDR_W + 1)'(DEPTH);
    localparam logic [MRM_CNT_W-1:0] CNT_INIT = MRM_CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    state_t               state_reg;
    logic [MRM_CNT_W-1:0] cnt_reg;
    logic                 load_reg;
    logic                 write_reg;
    logic [ADDR_W-1:0]    addr_reg;
    logic [DATA_W-1:0]    wdata_reg;

    logic                 req_load;
    logic                 req_write;
    logic [ADDR_W-1:0]    req_addr;
    logic [DATA_W-1:0]    req_wdata;
    logic                 req_legal;
    logic                 enter_respond;
    logic                 mem_we;
    logic [DATA_W-1:0]    mem_rdata;

    // With zero wait states the response happens on the accept edge, so the
    // live inputs must feed the datapath while still in IDLE.
    always_comb begin
        req_load  = load_reg;
        req_write = write_reg;
        req_addr  = addr_reg;
        req_wdata = wdata_reg;
        if (state_reg == IDLE) begin
            req_load  = load;
            req_write = mem_write;
            req_addr  = addr;
            req_wdata = wdata;
        end
    end

    assign req_legal     = is_legal(req_load, req_write, ({1'b0, req_addr} < DEPTH_L));
    assign enter_respond = ((state_reg == IDLE) && mem_enable && (WAIT_CYCLES == 0))
                         || ((state_reg == WAIT) && (cnt_reg == '0));
    assign mem_we        = enter_respond && req_legal && req_write && !reset;

    mem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_mem_array (
        .clk   (clk),
        .we    (mem_we),
        .addr  (req_addr),
        .wdata (req_wdata),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            load_reg  <= 1'b0;
            write_reg <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            rdata     <= '0;
            mem_ready <= 1'b0;
            mem_busy  <= 1'b0;
            mem_error <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    mem_ready <= 1'b0;
                    mem_error <= 1'b0;
                    if (mem_enable) begin
                        load_reg  <= load;
                        write_reg <= mem_write;
                        addr_reg  <= addr;
                        wdata_reg <= wdata;
                        mem_busy  <= 1'b1;
                        cnt_reg   <= CNT_INIT;
                        state_reg <= (WAIT_CYCLES > 0) ? WAIT : RESPOND;
                    end
                end
                WAIT: begin
                    if (cnt_reg != '0) begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end else begin
                        state_reg <= RESPOND;
                    end
                end
                RESPOND: begin
                    state_reg <= IDLE;
                    mem_ready <= 1'b0;
                    mem_busy  <= 1'b0;
                    mem_error <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    mem_ready <= 1'b0;
                    mem_busy  <= 1'b0;
                    mem_error <= 1'b0;
                end
            endcase

            // Completion side effects, shared by the IDLE and WAIT exits.
            if (enter_respond) begin
                mem_ready <= 1'b1;
                mem_busy  <= 1'b1;
                mem_error <= !req_legal;
                if (!req_legal) begin
                    rdata <= '0;
                end else if (req_load) begin
                    rdata <= mem_rdata;
                end
            end
        end
    end

endmodule
